// File: rtl/mul_border_mc.sv
// mul_border_mc: temporal-by-Sobol unary multiplier, one shared input pulse train against CH weight channels
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    synchronous active-low reset
//   init     load a new input magnitude, latch the weights, restart the sequence
//   clr      abort the current operation (weights kept, no completion pulse)
//   stall    freeze the counter and sequence index, force o_bit low
//   i_data_i input magnitude, i.e. the temporal pulse length in cycles
//   i_data_w packed weight magnitudes, channel c at [c*(WIDTH-1) +: WIDTH-1]
//   randW    shared threshold: bit-reversed sequence index
//   o_bit    per-channel product bitstream
//   i_bit_d  temporal input bit, forwarded to the neighbour PE
//   o_busy   high while the temporal count is nonzero
//   o_done   registered one-cycle completion pulse
//
// Optional feature, enabled by defining MUL_BORDER_MC_SIGN_EN:
//   i_sign_i, i_sign_w inputs and o_sign output; o_sign[c] = i_sign_i ^ i_sign_w[c],
//   latched on init and held until the next init or reset.
module mul_border_mc #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    input  logic                    clr,
    input  logic                    stall,
    input  logic [WIDTH-2:0]        i_data_i,
    input  logic [CH*(WIDTH-1)-1:0] i_data_w,
    output logic [WIDTH-2:0]        randW,
    output logic [CH-1:0]           o_bit,
    output logic                    i_bit_d,
    output logic                    o_busy,
    output logic                    o_done
`ifdef MUL_BORDER_MC_SIGN_EN
    ,
    input  logic                    i_sign_i,
    input  logic [CH-1:0]           i_sign_w,
    output logic [CH-1:0]           o_sign
`endif
);
    localparam int M = WIDTH - 1;

    logic [M-1:0] cnt;
    logic [M-1:0] idx;
    logic [M-1:0] wreg [CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= '0;
            o_done <= 1'b0;
            for (int c = 0; c < CH; c++) wreg[c] <= '0;
        end else if (init) begin
            cnt    <= i_data_i;
            idx    <= '0;
            // a zero-length operation completes immediately
            o_done <= (i_data_i == '0);
            for (int c = 0; c < CH; c++) wreg[c] <= i_data_w[c*M +: M];
        end else if (clr) begin
            cnt    <= '0;
            idx    <= '0;
            o_done <= 1'b0;
        end else if (stall) begin
            o_done <= 1'b0;
        end else if (i_bit_d) begin
            cnt    <= cnt - M'(1);
            idx    <= idx + M'(1);
            o_done <= (cnt == M'(1));
        end else begin
            o_done <= 1'b0;
        end
    end

`ifdef MUL_BORDER_MC_SIGN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) o_sign <= '0;
        else if (init) o_sign <= {CH{i_sign_i}} ^ i_sign_w;
    end
`endif

    assign i_bit_d = (cnt != '0);
    assign o_busy  = i_bit_d;

    // van der Corput threshold: MSB of randW is LSB of idx
    for (genvar i = 0; i < M; i++) begin : g_rev
        assign randW[i] = idx[M-1-i];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign o_bit[c] = i_bit_d & ~stall & (wreg[c] > randW);
    end
endmodule

// File: tb/tb_mul_border_mc.sv
// tb_mul_border_mc: table-driven directed check of mul_border_mc at WIDTH=8, CH=4
module tb_mul_border_mc;
    logic       clk = 1'b0;
    logic       rst_n, init, clr, stall;
    logic [6:0] i_data_i;
    logic [27:0] i_data_w;
    logic [6:0] randW;
    logic [3:0] o_bit;
    logic       i_bit_d, o_busy, o_done;
`ifdef MUL_BORDER_MC_SIGN_EN
    logic       i_sign_i;
    logic [3:0] i_sign_w, o_sign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_border_mc #(.WIDTH(8), .CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .clr(clr), .stall(stall),
        .i_data_i(i_data_i), .i_data_w(i_data_w), .randW(randW), .o_bit(o_bit),
        .i_bit_d(i_bit_d), .o_busy(o_busy), .o_done(o_done)
`ifdef MUL_BORDER_MC_SIGN_EN
        , .i_sign_i(i_sign_i), .i_sign_w(i_sign_w), .o_sign(o_sign)
`endif
    );

    typedef struct {
        logic       rst_n, init, clr, stall;
        logic [6:0] din;
        logic [6:0] rw;
        logic [3:0] bits;
        logic       busy, done;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic i, logic c, logic s, logic [6:0] d,
                                logic [6:0] rw, logic [3:0] b, logic bz, logic dn);
        vec_t v;
        v.rst_n = r; v.init = i; v.clr = c; v.stall = s; v.din = d;
        v.rw = rw; v.bits = b; v.busy = bz; v.done = dn;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic [6:0] rw, logic [3:0] b, logic bz, logic dn);
        chk({tag, " randW"}, int'(randW), int'(rw));
        chk({tag, " o_bit"}, int'(o_bit), int'(b));
        chk({tag, " o_busy"}, int'(o_busy), int'(bz));
        chk({tag, " i_bit_d"}, int'(i_bit_d), int'(bz));
        chk({tag, " o_done"}, int'(o_done), int'(dn));
    endtask

    initial begin
        // channel 0..3 weights = 0, 64, 127, 32
        i_data_w = {7'd32, 7'd127, 7'd64, 7'd0};
`ifdef MUL_BORDER_MC_SIGN_EN
        i_sign_i = 1'b1;
        i_sign_w = 4'b0101;
`endif
        // basic run: randW 0,64,32,96,16 -> per-channel ones 0,3,5,2
        tv.push_back(mk(1,1,0,0,7'd5, 7'd0,  4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd32, 4'b0110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd96, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd16, 4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd80, 4'b0000,0,1));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd80, 4'b0000,0,0));
        // stall for 3 cycles after the second bit
        tv.push_back(mk(1,1,0,0,7'd5, 7'd80, 4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,1,7'd0, 7'd32, 4'b0000,1,0));
        tv.push_back(mk(1,0,0,1,7'd0, 7'd32, 4'b0000,1,0));
        tv.push_back(mk(1,0,0,1,7'd0, 7'd32, 4'b0000,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd32, 4'b0110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd96, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd16, 4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd80, 4'b0000,0,1));
        // clr while cnt=3: no done pulse
        tv.push_back(mk(1,1,0,0,7'd5, 7'd80, 4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(1,0,1,0,7'd0, 7'd32, 4'b0110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,0));
        // zero-length init: done right after the init edge
        tv.push_back(mk(1,1,0,0,7'd0, 7'd0,  4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,1));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,0));
        // re-init (with clr) mid-count restarts with length 2
        tv.push_back(mk(1,1,0,0,7'd5, 7'd0,  4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,1,1,0,7'd2, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd32, 4'b0000,0,1));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd32, 4'b0000,0,0));
        // reset mid-count together with init/clr/stall
        tv.push_back(mk(1,1,0,0,7'd5, 7'd32, 4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b1110,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd64, 4'b0100,1,0));
        tv.push_back(mk(0,1,1,1,7'd7, 7'd32, 4'b0000,1,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,0));
        tv.push_back(mk(1,0,0,0,7'd0, 7'd0,  4'b0000,0,0));

        rst_n = 1'b0; init = 1'b1; clr = 1'b1; stall = 1'b1; i_data_i = 7'd9;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; init = 1'b0; clr = 1'b0; stall = 1'b0; i_data_i = '0;
        #4;
        check_outs("reset", 7'd0, 4'b0000, 1'b0, 1'b0);
`ifdef MUL_BORDER_MC_SIGN_EN
        chk("reset o_sign", int'(o_sign), 0);
`endif
        @(posedge clk);
        #1;

        for (int k = 0; k < tv.size(); k++) begin
            rst_n = tv[k].rst_n; init = tv[k].init; clr = tv[k].clr;
            stall = tv[k].stall; i_data_i = tv[k].din;
            #4;
            check_outs($sformatf("row%0d", k), tv[k].rw, tv[k].bits, tv[k].busy, tv[k].done);
            @(posedge clk);
            #1;
        end

`ifdef MUL_BORDER_MC_SIGN_EN
        // sign latched on init and held even when the sign inputs change
        rst_n = 1'b1; init = 1'b1; clr = 1'b0; stall = 1'b0; i_data_i = 7'd3;
        i_sign_i = 1'b1; i_sign_w = 4'b0101;
        @(posedge clk);
        #1;
        init = 1'b0; i_sign_i = 1'b0; i_sign_w = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk($sformatf("o_sign cyc%0d", k), int'(o_sign), int'(4'b1010));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        chk("o_sign after reset", int'(o_sign), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
